// File: rtl/frv_wide_writeback_pkg.sv
// Shared definitions for the wide writeback sequencer: state encoding and
// register-pair addressing helper.
package frv_wide_writeback_pkg;

    // Encoding is visible to trace/verification monitors; keep values stable.
    typedef enum logic [1:0] {
        FRV_WB_IDLE = 2'd0,
        FRV_WB_W1   = 2'd1,
        FRV_WB_W2   = 2'd2
    } frv_wb_state_e;

    localparam int unsigned FRV_WB_XLEN = 32;
    localparam int unsigned FRV_WB_RW   = 5;

    function automatic logic [FRV_WB_RW-1:0] frv_wb_pair_addr(
        input logic [FRV_WB_RW-1:0] rd,
        input logic                 hi
    );
        return {rd[FRV_WB_RW-1:1], hi};
    endfunction

endpackage

// File: rtl/frv_wide_writeback.sv
// Writeback sequencer: retires 32-bit results in one GPR write and 64-bit
// (mror) results as two writes to an even/odd register pair.
module frv_wide_writeback
    import frv_wide_writeback_pkg::*;
(
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        flush,
    input  logic        i_valid,
    output logic        i_ready,
    input  logic [63:0] i_result,
    input  logic [4:0]  i_rd,
    input  logic        i_wide,
    output logic        gpr_wen,
    output logic [4:0]  gpr_addr,
    output logic [31:0] gpr_wdata,
    output logic        retire,
    output logic        hz_valid,
    output logic [4:0]  hz_rd,
    output logic        hz_wide
);

    frv_wb_state_e r_state;
    frv_wb_state_e w_state_next;
    logic [63:0]   r_res;
    logic [4:0]    r_rd;
    logic          r_wide;
    logic          w_accept;

    // Ready depends on registered state only, never on i_valid.
    always_comb begin
        i_ready = 1'b0;
        case (r_state)
            FRV_WB_IDLE: i_ready = 1'b1;
            FRV_WB_W1:   i_ready = !r_wide;
            FRV_WB_W2:   i_ready = 1'b1;
            default:     i_ready = 1'b0;
        endcase
    end

    assign w_accept = i_valid && i_ready && !flush;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FRV_WB_IDLE: w_state_next = w_accept ? FRV_WB_W1 : FRV_WB_IDLE;
            FRV_WB_W1: begin
                if (r_wide) begin
                    w_state_next = FRV_WB_W2;
                end else begin
                    w_state_next = w_accept ? FRV_WB_W1 : FRV_WB_IDLE;
                end
            end
            FRV_WB_W2:   w_state_next = w_accept ? FRV_WB_W1 : FRV_WB_IDLE;
            default:     w_state_next = FRV_WB_IDLE;
        endcase
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_state <= FRV_WB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Flush only gates new captures; a held result is already committed.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_res  <= 64'd0;
            r_rd   <= 5'd0;
            r_wide <= 1'b0;
        end else if (w_accept) begin
            r_res  <= i_result;
            r_rd   <= i_rd;
            r_wide <= i_wide;
        end
    end

    always_comb begin
        gpr_addr  = r_rd;
        gpr_wdata = r_res[31:0];
        retire    = 1'b0;
        case (r_state)
            FRV_WB_W1: begin
                if (r_wide) begin
                    gpr_addr = frv_wb_pair_addr(r_rd, 1'b0);
                end else begin
                    retire   = 1'b1;
                end
            end
            FRV_WB_W2: begin
                gpr_addr  = frv_wb_pair_addr(r_rd, 1'b1);
                gpr_wdata = r_res[63:32];
                retire    = 1'b1;
            end
            default: begin
                gpr_addr  = r_rd;
                gpr_wdata = r_res[31:0];
            end
        endcase
    end

    // x0 is hardwired: the slot is still consumed, only the write is dropped.
    assign gpr_wen  = (r_state != FRV_WB_IDLE) && (gpr_addr != 5'd0);

    assign hz_valid = (r_state != FRV_WB_IDLE);
    assign hz_rd    = r_wide ? frv_wb_pair_addr(r_rd, 1'b0) : r_rd;
    assign hz_wide  = r_wide;

endmodule

// File: tb/tb_frv_wide_writeback.sv
// Directed self-checking bench for frv_wide_writeback.
module tb_frv_wide_writeback;

    logic        g_clk;
    logic        g_resetn;
    logic        flush;
    logic        i_valid;
    logic        i_ready;
    logic [63:0] i_result;
    logic [4:0]  i_rd;
    logic        i_wide;
    logic        gpr_wen;
    logic [4:0]  gpr_addr;
    logic [31:0] gpr_wdata;
    logic        retire;
    logic        hz_valid;
    logic [4:0]  hz_rd;
    logic        hz_wide;

    int total;
    int bad;

    frv_wide_writeback u_dut (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .flush     (flush),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .i_result  (i_result),
        .i_rd      (i_rd),
        .i_wide    (i_wide),
        .gpr_wen   (gpr_wen),
        .gpr_addr  (gpr_addr),
        .gpr_wdata (gpr_wdata),
        .retire    (retire),
        .hz_valid  (hz_valid),
        .hz_rd     (hz_rd),
        .hz_wide   (hz_wide)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic test_reset();
        g_resetn = 1'b0;
        flush    = 1'b0;
        i_valid  = 1'b0;
        i_result = 64'd0;
        i_rd     = 5'd0;
        i_wide   = 1'b0;
        #23;
        total++;
        if ({gpr_wen, retire, hz_valid, hz_wide, i_ready} !== 5'b00001) begin
            bad++;
            $display("FAIL reset_ctrl: got wen/ret/hzv/hzw/rdy=%b want 00001",
                     {gpr_wen, retire, hz_valid, hz_wide, i_ready});
        end
        total++;
        if (gpr_addr !== 5'd0 || gpr_wdata !== 32'd0) begin
            bad++;
            $display("FAIL reset_data: got addr=%0d data=%h want 0/0", gpr_addr, gpr_wdata);
        end
        @(negedge g_clk);
        g_resetn = 1'b1;
        tick();
    endtask

    task automatic test_narrow();
        i_valid = 1'b1; i_rd = 5'd5; i_result = 64'h0000_0000_DEAD_BEEF; i_wide = 1'b0;
        total++;
        if (i_ready !== 1'b1) begin
            bad++;
            $display("FAIL narrow_ready: got %b want 1", i_ready);
        end
        tick();
        i_valid = 1'b0;
        total++;
        if ({gpr_wen, retire} !== 2'b11 || gpr_addr !== 5'd5 || gpr_wdata !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL narrow_write: got wen=%b ret=%b addr=%0d data=%h want 1 1 5 deadbeef",
                     gpr_wen, retire, gpr_addr, gpr_wdata);
        end
        total++;
        if (hz_valid !== 1'b1 || hz_rd !== 5'd5 || hz_wide !== 1'b0) begin
            bad++;
            $display("FAIL narrow_hz: got v=%b rd=%0d w=%b want 1 5 0", hz_valid, hz_rd, hz_wide);
        end
        tick();
        total++;
        if ({hz_valid, gpr_wen, retire} !== 3'b000) begin
            bad++;
            $display("FAIL narrow_idle: got hzv/wen/ret=%b want 000", {hz_valid, gpr_wen, retire});
        end
    endtask

    task automatic test_wide();
        i_valid = 1'b1; i_rd = 5'd7; i_result = 64'h1111_2222_3333_4444; i_wide = 1'b1;
        tick();
        i_valid = 1'b0;
        total++;
        if ({gpr_wen, retire, i_ready} !== 3'b100 || gpr_addr !== 5'd6 ||
            gpr_wdata !== 32'h33334444) begin
            bad++;
            $display("FAIL wide_lo: got wen=%b ret=%b rdy=%b addr=%0d data=%h want 1 0 0 6 33334444",
                     gpr_wen, retire, i_ready, gpr_addr, gpr_wdata);
        end
        total++;
        if (hz_valid !== 1'b1 || hz_rd !== 5'd6 || hz_wide !== 1'b1) begin
            bad++;
            $display("FAIL wide_hz: got v=%b rd=%0d w=%b want 1 6 1", hz_valid, hz_rd, hz_wide);
        end
        tick();
        total++;
        if ({gpr_wen, retire, i_ready} !== 3'b111 || gpr_addr !== 5'd7 ||
            gpr_wdata !== 32'h11112222) begin
            bad++;
            $display("FAIL wide_hi: got wen=%b ret=%b rdy=%b addr=%0d data=%h want 1 1 1 7 11112222",
                     gpr_wen, retire, i_ready, gpr_addr, gpr_wdata);
        end
        tick();
        total++;
        if (hz_valid !== 1'b0 || retire !== 1'b0) begin
            bad++;
            $display("FAIL wide_idle: got hzv=%b ret=%b want 0 0", hz_valid, retire);
        end
    endtask

    task automatic test_back_to_back();
        i_valid = 1'b1; i_rd = 5'd3; i_result = 64'h0000_0000_0000_00AA; i_wide = 1'b0;
        tick();
        i_rd = 5'd10; i_result = 64'hB1B1_B1B1_B0B0_B0B0; i_wide = 1'b1;
        total++;
        if ({gpr_wen, retire, i_ready} !== 3'b111 || gpr_addr !== 5'd3 ||
            gpr_wdata !== 32'h000000AA) begin
            bad++;
            $display("FAIL b2b_w1: got wen=%b ret=%b rdy=%b addr=%0d data=%h want 1 1 1 3 000000aa",
                     gpr_wen, retire, i_ready, gpr_addr, gpr_wdata);
        end
        tick();
        // Present the third op while stalled; it must not be captured yet.
        i_rd = 5'd12; i_result = 64'h0000_0000_CCCC_CCCC; i_wide = 1'b0;
        total++;
        if ({gpr_wen, retire, i_ready} !== 3'b100 || gpr_addr !== 5'd10 ||
            gpr_wdata !== 32'hB0B0B0B0) begin
            bad++;
            $display("FAIL b2b_w2: got wen=%b ret=%b rdy=%b addr=%0d data=%h want 1 0 0 10 b0b0b0b0",
                     gpr_wen, retire, i_ready, gpr_addr, gpr_wdata);
        end
        tick();
        total++;
        if ({gpr_wen, retire, i_ready} !== 3'b111 || gpr_addr !== 5'd11 ||
            gpr_wdata !== 32'hB1B1B1B1) begin
            bad++;
            $display("FAIL b2b_w3: got wen=%b ret=%b rdy=%b addr=%0d data=%h want 1 1 1 11 b1b1b1b1",
                     gpr_wen, retire, i_ready, gpr_addr, gpr_wdata);
        end
        tick();
        i_valid = 1'b0;
        total++;
        if ({gpr_wen, retire} !== 2'b11 || gpr_addr !== 5'd12 || gpr_wdata !== 32'hCCCCCCCC) begin
            bad++;
            $display("FAIL b2b_w4: got wen=%b ret=%b addr=%0d data=%h want 1 1 12 cccccccc",
                     gpr_wen, retire, gpr_addr, gpr_wdata);
        end
        tick();
        total++;
        if (hz_valid !== 1'b0 || gpr_wen !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle: got hzv=%b wen=%b want 0 0", hz_valid, gpr_wen);
        end
    endtask

    task automatic test_x0();
        i_valid = 1'b1; i_rd = 5'd0; i_result = 64'h0000_0055_0000_0066; i_wide = 1'b1;
        tick();
        i_valid = 1'b0;
        total++;
        if ({gpr_wen, retire, hz_valid} !== 3'b001) begin
            bad++;
            $display("FAIL x0_wide_lo: got wen/ret/hzv=%b want 001", {gpr_wen, retire, hz_valid});
        end
        tick();
        total++;
        if ({gpr_wen, retire} !== 2'b11 || gpr_addr !== 5'd1 || gpr_wdata !== 32'h00000055) begin
            bad++;
            $display("FAIL x0_wide_hi: got wen=%b ret=%b addr=%0d data=%h want 1 1 1 00000055",
                     gpr_wen, retire, gpr_addr, gpr_wdata);
        end
        tick();
        i_valid = 1'b1; i_rd = 5'd0; i_result = 64'h0000_0000_1234_5678; i_wide = 1'b0;
        tick();
        i_valid = 1'b0;
        total++;
        if ({gpr_wen, retire, hz_valid} !== 3'b011) begin
            bad++;
            $display("FAIL x0_narrow: got wen/ret/hzv=%b want 011", {gpr_wen, retire, hz_valid});
        end
        tick();
    endtask

    task automatic test_flush();
        i_valid = 1'b1; flush = 1'b1; i_rd = 5'd9; i_result = 64'h0000_0000_9999_9999;
        i_wide = 1'b0;
        tick();
        i_valid = 1'b0; flush = 1'b0;
        total++;
        if ({hz_valid, gpr_wen, retire} !== 3'b000) begin
            bad++;
            $display("FAIL flush_idle: got hzv/wen/ret=%b want 000", {hz_valid, gpr_wen, retire});
        end
        i_valid = 1'b1; i_rd = 5'd20; i_result = 64'hAAAA_0001_BBBB_0002; i_wide = 1'b1;
        tick();
        i_valid = 1'b0; flush = 1'b1;
        total++;
        if (gpr_wen !== 1'b1 || gpr_addr !== 5'd20 || gpr_wdata !== 32'hBBBB0002) begin
            bad++;
            $display("FAIL flush_w1: got wen=%b addr=%0d data=%h want 1 20 bbbb0002",
                     gpr_wen, gpr_addr, gpr_wdata);
        end
        tick();
        flush = 1'b0;
        total++;
        if ({gpr_wen, retire} !== 2'b11 || gpr_addr !== 5'd21 || gpr_wdata !== 32'hAAAA0001) begin
            bad++;
            $display("FAIL flush_w2: got wen=%b ret=%b addr=%0d data=%h want 1 1 21 aaaa0001",
                     gpr_wen, retire, gpr_addr, gpr_wdata);
        end
        tick();
    endtask

    task automatic test_reset_w2();
        i_valid = 1'b1; i_rd = 5'd4; i_result = 64'h0000_00F5_0000_00F4; i_wide = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        total++;
        if (gpr_wen !== 1'b1 || gpr_addr !== 5'd5) begin
            bad++;
            $display("FAIL rst_pre: got wen=%b addr=%0d want 1 5", gpr_wen, gpr_addr);
        end
        #1;
        g_resetn = 1'b0;
        #1;
        total++;
        if ({gpr_wen, retire, hz_valid, i_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL rst_async: got wen/ret/hzv/rdy=%b want 0001",
                     {gpr_wen, retire, hz_valid, i_ready});
        end
        @(negedge g_clk);
        g_resetn = 1'b1;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_narrow();
        test_wide();
        test_back_to_back();
        test_x0();
        test_flush();
        test_reset_w2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frv_wide_writeback.md
# frv_wide_writeback

Writeback sequencer directly downstream of the execute-stage bitwise unit. It consumes the unit's 64-bit result and retires it into the single-write-port GPR file. A narrow result (funnel shift, cmov, bop, lut) is one 32-bit write. A wide result (mror) is two consecutive writes to an even/odd register pair. It also generates the per-instruction retire pulse and a pending-destination view for the hazard unit.

## Interface
- Parameters: none.
- `g_clk` in 1: core clock, rising edge.
- `g_resetn` in 1: asynchronous, active-low reset.
- `flush` in 1: pipeline flush.
- `i_valid` in 1: upstream result valid.
- `i_ready` out 1: block can accept a result this cycle.
- `i_result` in 64: result from bitwise unit.
- `i_rd` in 5: destination register.
- `i_wide` in 1: 1 = 64-bit pair write (mror), 0 = 32-bit write of `i_result[31:0]`.
- `gpr_wen` out 1: register-file write enable.
- `gpr_addr` out 5: write address.
- `gpr_wdata` out 32: write data.
- `retire` out 1: pulses on the final write cycle of each accepted result.
- `hz_valid` out 1: a result is held and not fully written.
- `hz_rd` out 5: held destination. For a wide op this is the pair base `{rd[4:1],1'b0}`.
- `hz_wide` out 1: held op is wide, so `hz_rd|1` is also pending.

## Operation
- States: IDLE (empty), W1 (first/only word is written this cycle), W2 (high word of a wide op is written this cycle).
- Accept occurs when `i_valid && i_ready && !flush`. On accept, the block captures `i_result`, `i_rd` and `i_wide`, and moves to W1.
- `i_ready` = (state==IDLE) || (state==W1 && !held_wide) || (state==W2). It is combinational from state only and never depends on `i_valid`.
- W1, narrow op:
  - Write `gpr_addr=rd`, `gpr_wdata=res[31:0]`, and pulse `retire`.
  - Next state is W1 on a new accept, otherwise IDLE.
- W1, wide op:
  - Write `gpr_addr={rd[4:1],1'b0}`, `gpr_wdata=res[31:0]`. `retire` stays low.
  - Next state is always W2.
- W2:
  - Write `gpr_addr={rd[4:1],1'b1}`, `gpr_wdata=res[63:32]`, and pulse `retire`.
  - Next state is W1 on a new accept, otherwise IDLE.
- The odd bit of `i_rd` is ignored for wide ops.
- x0 rule: when the computed `gpr_addr`==0, `gpr_wen` is 0. The cycle is still consumed, and `retire` still pulses if it is the final word. For a wide op to x0/x1, only x1 is written.
- Flush:
  - Blocks acceptance in the same cycle.
  - Does NOT cancel a held op, because held results are post-commit. W1→W2→IDLE completes normally.
- `hz_valid` = (state!=IDLE). `hz_rd` and `hz_wide` come from the holding register.
- `gpr_wdata`, `gpr_addr` and the holding register are don't-care when `gpr_wen`=0. They are held stable in IDLE.

## Timing
- Reset (async assert, sync deassert at the boundary): state=IDLE.
  - Outputs: `gpr_wen`=0, `retire`=0, `hz_valid`=0, `hz_wide`=0, `i_ready`=1.
  - Registers: holding registers=0, so `gpr_addr`=0 and `gpr_wdata`=0.
- Latency: accept at cycle N gives the first write at N+1. A wide op's second write is at N+2.
- Throughput:
  - Narrow ops: 1 per cycle, back-to-back.
  - Wide ops: 1 per 2 cycles.
  - An accept in W2 overlaps the high-word write with no bubble.
- `gpr_wen`, `gpr_addr`, `gpr_wdata` and `retire` are all combinational decodes of registered state and the holding register. There is no input-to-output combinational path.
- Reset asserted mid-W2: the state returns to IDLE immediately and the high word is lost. This is acceptable because the whole core resets.
- `i_valid` held with `i_ready`=0 (W1 wide): nothing is captured. Upstream must hold its data.

## Structure
- State encoding localparams (`FRV_WB_IDLE`, `FRV_WB_W1`, `FRV_WB_W2`, 2 bits) go in the shared core defines include, so the trace/verification monitors can decode them.
- Single flat module. No sub-module is warranted: the holding register plus a 3-state FSM is too small to split.

## Test plan
- Narrow single op:
  - Stimulus: accept `i_rd`=5, `i_result`=64'h0-DEADBEEF, `i_wide`=0.
  - Required: next cycle `gpr_wen`=1, `gpr_addr`=5, `gpr_wdata`=32'hDEADBEEF, `retire`=1. Then IDLE.
- Wide op:
  - Stimulus: `i_rd`=7, `i_result`=64'h11112222_33334444, `i_wide`=1.
  - Required: writes x6=33334444, then x7=11112222.
  - `retire` pulses only on the second write.
  - `i_ready`=0 during the first write cycle.
- Back-to-back:
  - Stimulus: `i_valid` held for narrow, wide, narrow.
  - Required: writes occur on 4 consecutive cycles with no bubble. The third op is accepted during W2.
- x0 target:
  - Stimulus: wide to `i_rd`=0.
  - Required: `gpr_wen`=0 in the first write cycle, 1 with `gpr_addr`=1 in the second. `retire` pulses once.
  - Also: a narrow op to x0 gives `gpr_wen`=0 and `retire`=1.
- Flush:
  - Stimulus: `flush`=1 in the same cycle as `i_valid`=1 in IDLE.
  - Required: no accept and no write.
  - Also: `flush` during W1 of a wide op leaves both writes intact.
- Reset:
  - Stimulus: assert `g_resetn`=0 asynchronously in W2.
  - Required: `gpr_wen` drops without waiting for a clock edge, and `i_ready`=1.
